// File: rtl/novelty_tx_scheduler_if.sv
// novelty_tx_scheduler_if
// Bundles the signals between the inference engine, uart_tx and the
// novelty TX scheduler.
//   echo_valid/echo_data          echo byte strobe and byte
//   alert_req/alert_addr/energy   novelty event strobe, weight address, energy
//   tx_busy                       uart_tx busy flag
//   tx_start/tx_data              start pulse and byte towards uart_tx
//   echo_drop                     echo push rejected (FIFO full)
//   alert_coalesced               pending alert overwritten by a newer one
//   alert_pending                 alert latched, frame not yet started
//   fifo_level                    echo FIFO occupancy
// Modports: master = producer/uart side (drives inputs of the scheduler),
//           slave  = the scheduler itself.
interface novelty_tx_scheduler_if #(
  parameter int unsigned ECHO_DEPTH = 8
);
  localparam int unsigned LVL_W = $clog2(ECHO_DEPTH) + 1;

  logic             echo_valid;
  logic [7:0]       echo_data;
  logic             alert_req;
  logic [3:0]       alert_addr;
  logic [15:0]      alert_energy;
  logic             tx_busy;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             echo_drop;
  logic             alert_coalesced;
  logic             alert_pending;
  logic [LVL_W-1:0] fifo_level;

  modport master (
    output echo_valid, echo_data, alert_req, alert_addr, alert_energy, tx_busy,
    input  tx_start, tx_data, echo_drop, alert_coalesced, alert_pending, fifo_level
  );

  modport slave (
    input  echo_valid, echo_data, alert_req, alert_addr, alert_energy, tx_busy,
    output tx_start, tx_data, echo_drop, alert_coalesced, alert_pending, fifo_level
  );
endinterface

// File: rtl/novelty_tx_scheduler.sv
// novelty_tx_scheduler
// Shares one uart_tx between the per-byte benchmark echo stream and novelty
// alert frames. Echo bytes queue in a small FIFO; alerts are latched in a
// single pending slot (newer alerts overwrite it) and sent as atomic frames
// of FRAME_HDR, {4'h0,addr}, energy[15:8], energy[7:0].
// Alerts win arbitration, but after STARVE_MAX consecutive alert frames with
// echo data waiting, one echo byte is forced through.
// Each byte is sequenced LOAD -> ISSUE (tx_start) -> WAIT_HI -> WAIT_LO; if
// tx_busy never rises within BUSY_TIMEOUT cycles the byte is counted as sent.
// Ports:
//   clk      system clock
//   reset_n  synchronous, active-low reset
//   bus      novelty_tx_scheduler_if.slave (see interface file)
// Build option: define ALERT_CHKSUM_EN to append a fifth frame byte holding
//   the XOR of frame bytes 2..4 (header excluded).
module novelty_tx_scheduler #(
  parameter int unsigned ECHO_DEPTH   = 8,
  parameter logic [7:0]  FRAME_HDR    = 8'hA5,
  parameter int unsigned STARVE_MAX   = 4,
  parameter int unsigned BUSY_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  novelty_tx_scheduler_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(ECHO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned IDX_W = 3;
`ifdef ALERT_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 5;
`else
  localparam int unsigned FRAME_LEN = 4;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t           state;
  logic             src_echo;
  logic [IDX_W-1:0] byte_idx;
  logic [TMR_W-1:0] timer;
  logic [STV_W-1:0] starve_cnt;
  logic             tx_start_q;
  logic [7:0]       tx_data_q;

  // Echo FIFO
  logic [7:0]       mem [ECHO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;
  logic             echo_drop_q;
  logic             full;
  logic             push;
  logic             pop;
  logic             echo_avail;

  // Alert pending slot and frame shadow copies
  logic             pending_q;
  logic             coalesced_q;
  logic [3:0]       slot_addr;
  logic [15:0]      slot_energy;
  logic [3:0]       sh_addr;
  logic [15:0]      sh_energy;

  logic             starved;
  logic             grant_alert;
  logic             grant_echo;
  logic [7:0]       frame_byte;

  always_comb begin
    full       = (count == LVL_W'(ECHO_DEPTH));
    pop        = (state == S_LOAD) && src_echo;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    push       = bus.echo_valid && (!full || pop);
    // An echo arriving this cycle is already eligible, giving push->LOAD in one cycle.
    echo_avail = (count != '0) || bus.echo_valid;
  end

  always_comb begin
    starved     = (starve_cnt == STV_W'(STARVE_MAX)) && echo_avail;
    grant_alert = (state == S_IDLE) && !bus.tx_busy && pending_q && !starved;
    grant_echo  = (state == S_IDLE) && !bus.tx_busy && echo_avail && !grant_alert;
  end

  always_comb begin
    frame_byte = FRAME_HDR;
    case (byte_idx)
      3'd0:    frame_byte = FRAME_HDR;
      3'd1:    frame_byte = {4'h0, sh_addr};
      3'd2:    frame_byte = sh_energy[15:8];
      3'd3:    frame_byte = sh_energy[7:0];
`ifdef ALERT_CHKSUM_EN
      3'd4:    frame_byte = {4'h0, sh_addr} ^ sh_energy[15:8] ^ sh_energy[7:0];
`endif
      default: frame_byte = FRAME_HDR;
    endcase
  end

  // FIFO storage has no reset; occupancy is tracked by the pointers/count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.echo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      echo_drop_q <= 1'b0;
    end else begin
      echo_drop_q <= bus.echo_valid && !push;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A request arriving on the frame-start cycle refills the slot just freed,
  // so it is not a coalesce.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending_q   <= 1'b0;
      coalesced_q <= 1'b0;
      slot_addr   <= '0;
      slot_energy <= '0;
    end else begin
      coalesced_q <= bus.alert_req && pending_q && !grant_alert;
      if (bus.alert_req) begin
        slot_addr   <= bus.alert_addr;
        slot_energy <= bus.alert_energy;
        pending_q   <= 1'b1;
      end else if (grant_alert) begin
        pending_q   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      src_echo   <= 1'b0;
      byte_idx   <= '0;
      timer      <= '0;
      starve_cnt <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      sh_addr    <= '0;
      sh_energy  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_alert) begin
            src_echo  <= 1'b0;
            byte_idx  <= '0;
            sh_addr   <= slot_addr;
            sh_energy <= slot_energy;
            state     <= S_LOAD;
          end else if (grant_echo) begin
            src_echo  <= 1'b1;
            byte_idx  <= '0;
            state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          tx_data_q  <= src_echo ? mem[rd_ptr] : frame_byte;
          tx_start_q <= 1'b1;
          state      <= S_ISSUE;
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bus.tx_busy || (timer == TMR_W'(BUSY_TIMEOUT - 1))) begin
            state <= S_WAIT_LO;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (!src_echo && (byte_idx != IDX_W'(FRAME_LEN - 1))) begin
              byte_idx <= byte_idx + 1'b1;
              state    <= S_LOAD;
            end else begin
              state    <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Starvation only accumulates across alert frames that overtook waiting echo data.
      if (grant_echo) begin
        starve_cnt <= '0;
      end else if (grant_alert) begin
        starve_cnt <= echo_avail ? starve_cnt + 1'b1 : '0;
      end else if (!echo_avail) begin
        starve_cnt <= '0;
      end
    end
  end

  assign bus.tx_start        = tx_start_q;
  assign bus.tx_data         = tx_data_q;
  assign bus.echo_drop       = echo_drop_q;
  assign bus.alert_coalesced = coalesced_q;
  assign bus.alert_pending   = pending_q;
  assign bus.fifo_level      = count;

endmodule

// File: tb/tb_novelty_tx_scheduler.sv
// tb_novelty_tx_scheduler
// Directed bench for novelty_tx_scheduler. A transaction-level model keeps the
// queue of bytes that must reach uart_tx, in order; one compare process checks
// every tx_start byte against it. A small uart_tx stand-in can respond
// normally, hold busy high, or never raise busy.
module tb_novelty_tx_scheduler;

  localparam int unsigned ECHO_DEPTH   = 8;
  localparam int unsigned BUSY_TIMEOUT = 15;
  localparam int unsigned UART_LEN     = 6;
`ifdef ALERT_CHKSUM_EN
  localparam int unsigned FRAME_LEN = 5;
`else
  localparam int unsigned FRAME_LEN = 4;
`endif

  typedef enum int { UM_AUTO, UM_HOLD, UM_DEAD } uart_mode_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  novelty_tx_scheduler_if #(.ECHO_DEPTH(ECHO_DEPTH)) bus ();

  novelty_tx_scheduler #(
    .ECHO_DEPTH  (ECHO_DEPTH),
    .FRAME_HDR   (8'hA5),
    .STARVE_MAX  (4),
    .BUSY_TIMEOUT(BUSY_TIMEOUT)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  exp_q[$];
  logic [7:0]  got_q[$];
  longint      start_cyc[$];
  longint      cyc = 0;
  int          drop_cnt = 0;
  int          coal_cnt = 0;
  uart_mode_t  uart_mode = UM_AUTO;
  int          ubusy = 0;
  logic        prev_start = 1'b0;
  logic [7:0]  exp_b;

  // ---------------- model ----------------
  task automatic exp_echo(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic exp_frame(input logic [3:0] a, input logic [15:0] e);
    exp_q.push_back(8'hA5);
    exp_q.push_back({4'h0, a});
    exp_q.push_back(e[15:8]);
    exp_q.push_back(e[7:0]);
    if (FRAME_LEN == 5) exp_q.push_back({4'h0, a} ^ e[15:8] ^ e[7:0]);
  endtask

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_echo(input logic [7:0] b);
    bus.echo_valid = 1'b1;
    bus.echo_data  = b;
    tick(1);
    bus.echo_valid = 1'b0;
  endtask

  task automatic raise_alert(input logic [3:0] a, input logic [15:0] e);
    bus.alert_req    = 1'b1;
    bus.alert_addr   = a;
    bus.alert_energy = e;
    tick(1);
    bus.alert_req    = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int unsigned k = 0;
    while (k < 3000 && !(exp_q.size() == 0 && bus.fifo_level == '0 &&
                         !bus.alert_pending && !bus.tx_busy)) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (k >= 3000) begin
      n_fail++;
      $display("FAIL %s_drain: %0d bytes still outstanding, required 0 within 3000 cycles",
               name, exp_q.size());
    end
    tick(25);
  endtask

  task automatic wait_starts(input string name, input int target);
    int unsigned k = 0;
    while (k < 500 && start_cyc.size() < target) begin
      tick(1);
      k++;
    end
    n_checks++;
    if (start_cyc.size() < target) begin
      n_fail++;
      $display("FAIL %s_wait: got %0d tx_start pulses, required %0d within 500 cycles",
               name, start_cyc.size(), target);
    end
  endtask

  // ---------------- cycle counter ----------------
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- uart_tx stand-in (acts 2 ns after the edge) ----------------
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (uart_mode)
        UM_HOLD: begin bus.tx_busy = 1'b1; ubusy = 0; end
        UM_DEAD: begin bus.tx_busy = 1'b0; ubusy = 0; end
        default: begin
          if (ubusy != 0) begin
            ubusy--;
            bus.tx_busy = (ubusy != 0);
          end else if (bus.tx_start) begin
            ubusy = UART_LEN;
            bus.tx_busy = 1'b1;
          end else begin
            bus.tx_busy = 1'b0;
          end
        end
      endcase
    end
  end

  // ---------------- compare process ----------------
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (bus.echo_drop) drop_cnt++;
      if (bus.alert_coalesced) coal_cnt++;
      if (bus.tx_start) begin
        got_q.push_back(bus.tx_data);
        start_cyc.push_back(cyc);
        n_checks++;
        if (prev_start) begin
          n_fail++;
          $display("FAIL tx_start_width: got high on consecutive cycles, required 1-cycle pulse");
        end else if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: got 0x%0h, required no byte", bus.tx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (bus.tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL tx_byte: got 0x%0h, required 0x%0h", bus.tx_data, exp_b);
          end
        end
      end
    end
    prev_start = bus.tx_start;
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] lit [5];
  int d0;
  int s0;

  initial begin
    lit[0] = 8'hA5; lit[1] = 8'h05; lit[2] = 8'h12; lit[3] = 8'h34; lit[4] = 8'h23;
    bus.echo_valid   = 1'b0;
    bus.echo_data    = '0;
    bus.alert_req    = 1'b0;
    bus.alert_addr   = '0;
    bus.alert_energy = '0;
    reset_n = 1'b0;
    tick(3);

    // 1: reset state, then single echo latency
    check("rst_tx_start",  32'(bus.tx_start), 0);
    check("rst_tx_data",   32'(bus.tx_data), 0);
    check("rst_echo_drop", 32'(bus.echo_drop), 0);
    check("rst_coalesced", 32'(bus.alert_coalesced), 0);
    check("rst_pending",   32'(bus.alert_pending), 0);
    check("rst_level",     32'(bus.fifo_level), 0);
    reset_n = 1'b1;
    tick(2);

    exp_echo(8'h3C);
    push_echo(8'h3C);
    check("t1_start_n1", 32'(bus.tx_start), 0);
    check("t1_level_n1", 32'(bus.fifo_level), 1);
    tick(1);
    check("t1_start_n2", 32'(bus.tx_start), 1);
    check("t1_data_n2",  32'(bus.tx_data), 32'h3C);
    check("t1_level_n2", 32'(bus.fifo_level), 0);
    wait_drain("t1");

    // 2: fill while busy, overflow drop, push+pop while full
    uart_mode = UM_HOLD;
    tick(2);
    d0 = drop_cnt;
    for (int i = 0; i < 9; i++) begin
      bus.echo_valid = 1'b1;
      bus.echo_data  = 8'(8'h10 + i);
      if (i < 8) exp_echo(8'(8'h10 + i));
      tick(1);
    end
    bus.echo_valid = 1'b0;
    tick(1);
    check("t2_level_full", 32'(bus.fifo_level), 8);
    check("t2_drop_once",  32'(drop_cnt - d0), 1);
    check("t2_no_start",   32'(start_cyc.size()), 1);
    uart_mode = UM_AUTO;
    tick(1);
    // FSM is in LOAD now (popping); a push here must succeed without a drop
    exp_echo(8'h20);
    push_echo(8'h20);
    check("t2_level_pushpop", 32'(bus.fifo_level), 8);
    wait_drain("t2");
    check("t2_drop_total", 32'(drop_cnt - d0), 1);

    // 3: single alert frame, pinned against literal bytes
    got_q.delete();
    exp_frame(4'h5, 16'h1234);
    raise_alert(4'h5, 16'h1234);
    check("t3_pending", 32'(bus.alert_pending), 1);
    wait_drain("t3");
    check("t3_frame_len", 32'(got_q.size()), FRAME_LEN);
    for (int i = 0; i < FRAME_LEN; i++) begin
      if (i < got_q.size()) check($sformatf("t3_lit_byte%0d", i), 32'(got_q[i]), 32'(lit[i]));
    end

    // 4: two alerts while a frame is in flight -> one coalesce, last values win
    d0 = coal_cnt;
    exp_frame(4'h1, 16'h1111);
    raise_alert(4'h1, 16'h1111);
    tick(4);
    raise_alert(4'h2, 16'h2222);
    check("t4_pending", 32'(bus.alert_pending), 1);
    tick(2);
    exp_frame(4'h3, 16'h3333);
    raise_alert(4'h3, 16'h3333);
    tick(2);
    check("t4_coalesced", 32'(coal_cnt - d0), 1);
    wait_drain("t4");
    check("t4_coalesced_total", 32'(coal_cnt - d0), 1);

    // 5: continuous alerts with one echo waiting -> 4 frames, echo, alerts resume
    got_q.delete();
    uart_mode = UM_HOLD;
    tick(2);
    raise_alert(4'h7, 16'h0700);
    push_echo(8'hE1);
    exp_frame(4'h7, 16'h0700);
    for (int i = 1; i <= 3; i++) exp_frame(4'(i), 16'(16'h5000 + i));
    exp_echo(8'hE1);
    for (int i = 4; i <= 5; i++) exp_frame(4'(i), 16'(16'h5000 + i));
    uart_mode = UM_AUTO;
    begin
      int n = 1;
      int k = 0;
      while (n <= 5 && k < 2000) begin
        if (!bus.alert_pending) begin
          raise_alert(4'(n), 16'(16'h5000 + n));
          n++;
        end else begin
          tick(1);
        end
        k++;
      end
      check("t5_alerts_raised", 32'(n), 6);
    end
    wait_drain("t5");
    check("t5_byte_count", 32'(got_q.size()), 6 * FRAME_LEN + 1);
    if (got_q.size() > 4 * FRAME_LEN)
      check("t5_echo_slot", 32'(got_q[4 * FRAME_LEN]), 32'hE1);

    // 6: tx_busy never rises -> timeout advances; then reset mid-frame
    uart_mode = UM_DEAD;
    tick(2);
    s0 = start_cyc.size();
    exp_echo(8'h77);
    exp_echo(8'h78);
    push_echo(8'h77);
    push_echo(8'h78);
    wait_starts("t6_timeout", s0 + 2);
    // ISSUE + BUSY_TIMEOUT wait cycles + WAIT_LO + IDLE + LOAD
    if (start_cyc.size() >= s0 + 2)
      check("t6_timeout_gap", 32'(start_cyc[s0 + 1] - start_cyc[s0]), 1 + BUSY_TIMEOUT + 3);
    wait_drain("t6a");

    s0 = start_cyc.size();
    exp_frame(4'h9, 16'hABCD);
    raise_alert(4'h9, 16'hABCD);
    wait_starts("t6_frame", s0 + 1);
    tick(3);
    push_echo(8'h5A);
    raise_alert(4'hC, 16'h0C0C);
    check("t6_level_pre", 32'(bus.fifo_level), 1);
    check("t6_pending_pre", 32'(bus.alert_pending), 1);
    reset_n = 1'b0;
    tick(1);
    check("t6_rst_tx_start",  32'(bus.tx_start), 0);
    check("t6_rst_tx_data",   32'(bus.tx_data), 0);
    check("t6_rst_echo_drop", 32'(bus.echo_drop), 0);
    check("t6_rst_coalesced", 32'(bus.alert_coalesced), 0);
    check("t6_rst_pending",   32'(bus.alert_pending), 0);
    check("t6_rst_level",     32'(bus.fifo_level), 0);
    exp_q.delete();
    s0 = start_cyc.size();
    tick(3);
    reset_n = 1'b1;
    tick(40);
    check("t6_quiet_after_rst", 32'(start_cyc.size() - s0), 0);
    check("t6_level_after_rst", 32'(bus.fifo_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
